vga_timing_param: RTL and testbench

// - Parametrised VGA timing generator; next generation of the fixed 1024x768 timing block.
// - Generates hcount/vcount, hsync/vsync and hblnk/vblnk on the vga_if bus for any mode via parameters.
// - Adds a pixel-clock enable, programmable sync polarity, a synchronous restart, and line/frame start strobes.
// - Sits at the head of the video pipeline and drives the first draw stage.

---
 rtl/vga_if.sv | 17 +
 rtl/vga_timing_param.sv | 112 +++++++++++
 tb/tb_vga_timing_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// Video timing bus between the timing generator and the first draw stage.
// CNT_W sizes the pixel/line counters and must match the generator's CNT_W.
interface vga_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic [11:0]      rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator with pixel enable, restart and line/frame strobes.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module vga_timing_param #(
  parameter int   H_ACTIVE  = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_ACTIVE  = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   CNT_W     = 11
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  restart,
  vga_if.out    out,
  output logic  line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic  frame_start,
  output logic [15:0] frame_cnt
`else
  output logic  frame_start
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("vga_timing_param: H_*/V_* timing parameters must be non-zero");
  end
  if (CNT_W < 1 || CNT_W > 30 || (1 << CNT_W) < MAX_TOTAL) begin : g_bad_cnt_w
    $error("vga_timing_param: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;

  assign h_wrap = (out.hcount == H_LAST);
  assign v_wrap = (out.vcount == V_LAST);

  // Restart overrides the natural wrap so the pipeline can be resynchronised mid-frame.
  always_comb begin
    h_nxt = out.hcount;
    v_nxt = out.vcount;
    if (restart) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_wrap) begin
      h_nxt = '0;
      v_nxt = v_wrap ? '0 : out.vcount + 1'b1;
    end else begin
      h_nxt = out.hcount + 1'b1;
    end
  end

  assign out.rgb = 12'h000;

  // Flags decode the next counts so they land in the same register stage as the counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.hcount  <= '0;
      out.vcount  <= '0;
      out.hblnk   <= 1'b0;
      out.vblnk   <= 1'b0;
      out.hsync   <= ~HSYNC_POL;
      out.vsync   <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        out.hcount  <= h_nxt;
        out.vcount  <= v_nxt;
        out.hblnk   <= (h_nxt >= H_ACT);
        out.vblnk   <= (v_nxt >= V_ACT);
        out.hsync   <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        out.vsync   <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        line_start  <= (h_nxt == '0);
        frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (en) begin
      if (restart) frame_cnt <= 16'd0;
      else if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vga_timing_param.sv
// Bench: small-mode instance (inverted polarity) against a linear pixel-index model under random
// en/restart/rst, plus a default-mode instance checked over one full line.
module tb_vga_timing_param;
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 25
  localparam int VT = VA + VF + VS + VB;  // 14
  localparam int TOT = HT * VT;           // 350
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, restart, line_start, frame_start;
  vga_if #(.CNT_W(CW)) vs ();
  logic rst_d, en_d, restart_d, ls_d, fs_d;
  vga_if vd ();
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt, fc_d;
`endif

  vga_timing_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .out(vs),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
`else
    .line_start(line_start), .frame_start(frame_start)
`endif
  );

  vga_timing_param dut_def (
    .clk(clk), .rst(rst_d), .en(en_d), .restart(restart_d), .out(vd),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
`else
    .line_start(ls_d), .frame_start(fs_d)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: position is one linear pixel index over the whole frame.
  int p, m_fc;
  bit m_ls, m_fs, cmp_on;

  task automatic model_reset();
    p = 0; m_ls = 0; m_fs = 0; m_fc = 0;
  endtask

  task automatic model_upd(input bit r_rst, input bit e, input bit r);
    int np;
    if (r_rst) model_reset();
    else if (!e) begin m_ls = 0; m_fs = 0; end
    else if (r) begin p = 0; m_ls = 1; m_fs = 1; m_fc = 0; end
    else begin
      np = (p + 1) % TOT;
      m_ls = (np % HT == 0);
      m_fs = (np == 0);
      if (np == 0) m_fc = (m_fc + 1) % 65536;
      p = np;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      int h, v;
      h = p % HT;
      v = p / HT;
      chk("hcount", 32'(vs.hcount), h);
      chk("vcount", 32'(vs.vcount), v);
      chk("hblnk", 32'(vs.hblnk), (h >= HA) ? 1 : 0);
      chk("vblnk", 32'(vs.vblnk), (v >= VA) ? 1 : 0);
      chk("hsync", 32'(vs.hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
      chk("vsync", 32'(vs.vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
      chk("rgb", 32'(vs.rgb), 0);
      chk("line_start", 32'(line_start), 32'(m_ls));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), m_fc);
`endif
    end
  end

  // One clock edge with the current inputs, then apply the next inputs at posedge+1.
  task automatic step(input bit n_en, input bit n_rs);
    bit e, r, rr;
    e = en; r = restart; rr = rst;
    @(posedge clk);
    #1;
    model_upd(rr, e, r);
    en = n_en;
    restart = n_rs;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic run_default();
    rst_d = 1'b1; en_d = 1'b0; restart_d = 1'b0;
    @(posedge clk); #1;
    rst_d = 1'b0;
    chk("def_rst_hsync", 32'(vd.hsync), 0);
    chk("def_rst_vsync", 32'(vd.vsync), 0);
    en_d = 1'b1;
    for (int k = 1; k <= 1345; k++) begin
      @(posedge clk); #1;
      case (k)
        1023: chk("def_hblnk_1023", 32'(vd.hblnk), 0);
        1024: begin
          chk("def_h_1024", 32'(vd.hcount), 1024);
          chk("def_hblnk_1024", 32'(vd.hblnk), 1);
        end
        1047: chk("def_hsync_1047", 32'(vd.hsync), 0);
        1048: chk("def_hsync_1048", 32'(vd.hsync), 1);
        1183: chk("def_hsync_1183", 32'(vd.hsync), 1);
        1184: chk("def_hsync_1184", 32'(vd.hsync), 0);
        1343: begin
          chk("def_h_1343", 32'(vd.hcount), 1343);
          chk("def_v_before_wrap", 32'(vd.vcount), 0);
        end
        1344: begin
          chk("def_h_wrap", 32'(vd.hcount), 0);
          chk("def_v_wrap", 32'(vd.vcount), 1);
          chk("def_line_start", 32'(ls_d), 1);
          chk("def_frame_start", 32'(fs_d), 0);
          chk("def_vblnk", 32'(vd.vblnk), 0);
          chk("def_vsync", 32'(vd.vsync), 0);
        end
        default: ;
      endcase
    end
    en_d = 1'b0;
  endtask

  task automatic run_small();
    rst = 1'b1; en = 1'b0; restart = 1'b0; cmp_on = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_on = 1;
    chk("rst_hcount", 32'(vs.hcount), 0);
    chk("rst_hsync_idle", 32'(vs.hsync), 1);
    chk("rst_vsync_idle", 32'(vs.vsync), 1);
    chk("rst_line_start", 32'(line_start), 0);

    // en pattern 1,0,0,1 -> advances by two
    en = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("en_toggle_h", 32'(vs.hcount), 2);

    // walk to (19,9): inside both sync windows
    en = 1'b1;
    repeat (241) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("mid_h", 32'(vs.hcount), 19);
    chk("mid_v", 32'(vs.vcount), 9);
    chk("mid_hsync_on", 32'(vs.hsync), 0);
    chk("mid_vsync_on", 32'(vs.vsync), 0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_h", 32'(vs.hcount), 0);
    chk("async_rst_v", 32'(vs.vcount), 0);
    chk("async_rst_hsync", 32'(vs.hsync), 1);
    chk("async_rst_vsync", 32'(vs.vsync), 1);
    step(1'b0, 1'b0);
    rst = 1'b0;

    // restart at (10,5)
    en = 1'b1;
    repeat (134) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("pre_restart_h", 32'(vs.hcount), 10);
    chk("pre_restart_v", 32'(vs.vcount), 5);
    step(1'b0, 1'b0);
    chk("restart_h", 32'(vs.hcount), 0);
    chk("restart_v", 32'(vs.vcount), 0);
    chk("restart_ls", 32'(line_start), 1);
    chk("restart_fs", 32'(frame_start), 1);
    // restart with en=0 is ignored
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("restart_no_en_h", 32'(vs.hcount), 0);
    chk("restart_no_en_fs", 32'(frame_start), 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    pulse_rst();
    en = 1'b1;
    repeat (3 * TOT - 1) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("three_frames_cnt", 32'(frame_cnt), 3);
    chk("three_frames_fs", 32'(frame_start), 1);
`endif

    repeat (6000) begin
      if ($urandom_range(0, 999) == 0) pulse_rst();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    step(1'b0, 1'b0);
    @(negedge clk);
    cmp_on = 0;
  endtask

  initial begin
    fork
      run_small();
      run_default();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
